// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio rate definitions and NCO increment helper
package audio_pkg;

  typedef enum logic [1:0] {
    RATE_48K  = 2'd0,
    RATE_44K1 = 2'd1,
    RATE_32K  = 2'd2,
    RATE_96K  = 2'd3
  } rate_e;

  // Sample rate in Hz, indexed by rate_sel
  localparam longint unsigned RATE_HZ [4] = '{48000, 44100, 32000, 96000};

  // Phase step per clock so the accumulator carries at twice the sample rate
  function automatic longint unsigned calc_inc(input longint unsigned clk_hz,
                                               input longint unsigned rate,
                                               input int              acc_bits);
    return ((rate << (acc_bits + 1)) + (clk_hz >> 1)) / clk_hz;
  endfunction

endpackage

// File: rtl/audio_nco.sv
// rtl/audio_nco.sv - phase accumulator whose carry toggles clk_audio
// tick flags the carry that is about to drive clk_audio 0->1.
module audio_nco #(
  parameter int ACC_BITS = 24
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic                clear,
  input  logic [ACC_BITS-1:0] inc,
  output logic                tick,
  output logic                clk_audio
);

  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS:0]   sum;
  logic                carry;

  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign carry = sum[ACC_BITS];
  assign tick  = carry & ~clk_audio & ~clear & ~reset;

  always_ff @(posedge clk_pixel) begin
    if (reset || clear) begin
      acc       <= '0;
      clk_audio <= 1'b0;
    end else begin
      acc <= sum[ACC_BITS-1:0];
      if (carry) begin
        clk_audio <= ~clk_audio;
      end
    end
  end

endmodule

// File: rtl/audio_rate_gen.sv
// rtl/audio_rate_gen.sv - HDMI audio rate generator and sample latch
// Define AUDIO_RATE_SOFTMUTE_EN for a 16-step gain ramp on mute instead of hard zeroing.
module audio_rate_gen
  import audio_pkg::*;
#(
  parameter int CLK_HZ   = 32000000,
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int ACC_BITS = 24
) (
  input  logic                      clk_pixel,
  input  logic                      reset,
  input  logic [1:0]                rate_sel,
  input  logic                      mute,
  input  logic [CHANNELS*WIDTH-1:0] audio_in,
  output logic [CHANNELS*WIDTH-1:0] audio_out,
  output logic                      clk_audio,
  output logic                      sample_stb
);

  localparam logic [ACC_BITS-1:0] INC_48K  = ACC_BITS'(calc_inc(64'(CLK_HZ), RATE_HZ[0], ACC_BITS));
  localparam logic [ACC_BITS-1:0] INC_44K1 = ACC_BITS'(calc_inc(64'(CLK_HZ), RATE_HZ[1], ACC_BITS));
  localparam logic [ACC_BITS-1:0] INC_32K  = ACC_BITS'(calc_inc(64'(CLK_HZ), RATE_HZ[2], ACC_BITS));
  localparam logic [ACC_BITS-1:0] INC_96K  = ACC_BITS'(calc_inc(64'(CLK_HZ), RATE_HZ[3], ACC_BITS));

  rate_e               rate_q;
  logic                rate_chg;
  logic [ACC_BITS-1:0] inc;
  logic                tick;

  // Loaded every cycle, reset included, so the first rate after reset never counts as a change
  always_ff @(posedge clk_pixel) begin
    rate_q <= rate_e'(rate_sel);
  end

  assign rate_chg = (rate_e'(rate_sel) != rate_q);

  always_comb begin
    inc = INC_48K;
    case (rate_q)
      RATE_48K:  inc = INC_48K;
      RATE_44K1: inc = INC_44K1;
      RATE_32K:  inc = INC_32K;
      RATE_96K:  inc = INC_96K;
      default:   inc = INC_48K;
    endcase
  end

  audio_nco #(
    .ACC_BITS (ACC_BITS)
  ) u_nco (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .clear     (rate_chg),
    .inc       (inc),
    .tick      (tick),
    .clk_audio (clk_audio)
  );

`ifdef AUDIO_RATE_SOFTMUTE_EN
  localparam logic [4:0] GAIN_UNITY = 5'd16;

  logic [4:0]                gain;
  logic [4:0]                gain_nxt;
  logic [CHANNELS*WIDTH-1:0] scaled;

  always_comb begin
    gain_nxt = gain;
    if (mute && (gain != 5'd0)) begin
      gain_nxt = gain - 5'd1;
    end else if (!mute && (gain != GAIN_UNITY)) begin
      gain_nxt = gain + 5'd1;
    end
  end

  // Output uses the gain after this strobe's step, so strobe k of a mute lands on 16-k
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic signed [WIDTH+5:0] samp;
    logic signed [WIDTH+5:0] gmul;
    logic signed [WIDTH+5:0] prod;
    logic                    unused_prod_bits;

    assign samp  = {{6{audio_in[ch*WIDTH+WIDTH-1]}}, audio_in[ch*WIDTH +: WIDTH]};
    assign gmul  = {{(WIDTH+1){1'b0}}, gain_nxt};
    assign prod  = samp * gmul;
    assign scaled[ch*WIDTH +: WIDTH] = prod[WIDTH+3:4];
    assign unused_prod_bits = ^{prod[WIDTH+5:WIDTH+4], prod[3:0]};
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      gain       <= GAIN_UNITY;
      sample_stb <= 1'b0;
      audio_out  <= '0;
    end else begin
      sample_stb <= tick;
      if (tick) begin
        gain      <= gain_nxt;
        audio_out <= scaled;
      end
    end
  end
`else
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      sample_stb <= 1'b0;
      audio_out  <= '0;
    end else begin
      sample_stb <= tick;
      if (tick) begin
        audio_out <= mute ? '0 : audio_in;
      end
    end
  end
`endif

endmodule

// File: tb/tb_audio_rate_gen.sv
// tb/tb_audio_rate_gen.sv - scoreboard bench for audio_rate_gen at 32 MHz
// Honours AUDIO_RATE_SOFTMUTE_EN for the mute expectations.
module tb_audio_rate_gen;

  localparam int CHANNELS = 2;
  localparam int WIDTH    = 16;
  localparam int DW       = CHANNELS * WIDTH;
  localparam int WAIT_MAX = 2000;

  logic          clk_pixel;
  logic          reset;
  logic [1:0]    rate_sel;
  logic          mute;
  logic [DW-1:0] audio_in;
  logic [DW-1:0] audio_out;
  logic          clk_audio;
  logic          sample_stb;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] sb_e;
  logic [DW-1:0] held     = '0;
  logic          hold_chk = 1'b0;

  audio_rate_gen #(
    .CLK_HZ   (32000000),
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .ACC_BITS (24)
  ) dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .rate_sel   (rate_sel),
    .mute       (mute),
    .audio_in   (audio_in),
    .audio_out  (audio_out),
    .clk_audio  (clk_audio),
    .sample_stb (sample_stb)
  );

  initial begin
    clk_pixel = 1'b0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Cycles until the next strobe cycle; returns at posedge+1 after it
  task automatic wait_stb(input string name, output int n);
    int k;
    for (k = 0; k < WAIT_MAX; k++) begin
      @(negedge clk_pixel);
      if (sample_stb) break;
    end
    n = k + 1;
    if (k == WAIT_MAX) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no sample_stb expected one within %0d cycles", name, WAIT_MAX);
    end
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic run_window(input int cycles, input bit chk_phase, output int nstb);
    int   last;
    bit   have;
    logic prev;
    nstb = 0;
    last = 0;
    have = 1'b0;
    prev = clk_audio;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_pixel);
      if (sample_stb) nstb++;
      if (clk_audio !== prev) begin
        if (chk_phase && have) check_rng("phase_len_48k", i - last, 333, 334);
        have = 1'b1;
        last = i;
        prev = clk_audio;
      end
    end
  endtask

  function automatic logic [DW-1:0] ramp(input int g);
    int a;
    int b;
    a = 16384 * g / 16;
    b = -16384 * g / 16;
    return {16'(a), 16'(b)};
  endfunction

  // Monitor: every strobe with a pending expectation is scored
  always @(negedge clk_pixel) begin
    if (!reset && sample_stb && sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      check("sb_audio_out", audio_out, sb_e);
      check("sb_clk_audio_high", clk_audio, 1);
      held = sb_e;
    end else if (hold_chk && !reset) begin
      check("hold_audio_out", audio_out, held);
    end
  end

  initial begin
    int n;
    reset    = 1'b1;
    rate_sel = 2'd0;
    mute     = 1'b0;
    audio_in = '0;
    repeat (2) @(posedge clk_pixel);
    #1;
    check("rst_clk_audio", clk_audio, 0);
    check("rst_sample_stb", sample_stb, 0);
    check("rst_audio_out", audio_out, 0);

    audio_in = {16'h1234, 16'hF00D};
    sb_q.push_back({16'h1234, 16'hF00D});
    reset = 1'b0;
    wait_stb("first_stb", n);
    check_rng("first_stb_latency", n - 1, 332, 334);

    hold_chk = 1'b1;
    audio_in = {16'h7FFF, 16'h8001};
    sb_q.push_back({16'h7FFF, 16'h8001});
    wait_stb("hold_stb", n);
    check_rng("stb_spacing_48k", n, 666, 667);
    hold_chk = 1'b0;

    audio_in = {16'h4000, 16'hC000};
    mute     = 1'b1;
`ifdef AUDIO_RATE_SOFTMUTE_EN
    for (int k = 1; k <= 16; k++) sb_q.push_back(ramp(16 - k));
    for (int k = 1; k <= 16; k++) wait_stb("mute_down", n);
    mute = 1'b0;
    for (int k = 1; k <= 16; k++) sb_q.push_back(ramp(k));
    for (int k = 1; k <= 16; k++) wait_stb("mute_up", n);
`else
    sb_q.push_back('0);
    wait_stb("mute_on", n);
    mute = 1'b0;
    sb_q.push_back(ramp(16));
    wait_stb("mute_off", n);
`endif

    repeat (200) @(posedge clk_pixel);
    #1;
    check("pre_chg_clk_audio", clk_audio, 1);
    rate_sel = 2'd2;
    @(posedge clk_pixel);
    #1;
    check("chg_acc_zero", dut.u_nco.acc, 0);
    check("chg_clk_audio", clk_audio, 0);
    check("chg_sample_stb", sample_stb, 0);
    wait_stb("stb_32k_a", n);
    wait_stb("stb_32k_b", n);
    check_rng("stb_spacing_32k", n, 999, 1001);

    rate_sel = 2'd0;
    run_window(32000, 1'b1, n);
    check_rng("strobes_48k", n, 47, 49);
    rate_sel = 2'd1;
    run_window(8000, 1'b0, n);
    check_rng("strobes_44k1", n, 10, 12);
    rate_sel = 2'd3;
    run_window(4000, 1'b0, n);
    check_rng("strobes_96k", n, 11, 13);

    rate_sel = 2'd0;
    audio_in = {16'h55AA, 16'h0F0F};
    sb_q.push_back({16'h55AA, 16'h0F0F});
    wait_stb("pre_rst_stb", n);
    repeat (100) @(posedge clk_pixel);
    #1;
    check("pre_rst_clk_audio", clk_audio, 1);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_pixel);
      #1;
      check("mid_rst_clk_audio", clk_audio, 0);
      check("mid_rst_sample_stb", sample_stb, 0);
      check("mid_rst_audio_out", audio_out, 0);
    end
    reset = 1'b0;
    wait_stb("post_rst_stb", n);
    check_rng("post_rst_latency", n - 1, 332, 334);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
